am2906_xq: RTL and testbench
============================

Name: am2906_xq

Overview:
- Parametrised successor to the am29xx parity bus transceiver.
- Operands from A/B are queued in a transmit FIFO and driven onto an active-low open-collector bus under a request/grant handshake, with a generated parity line.
- Receive side samples the bus synchronously and checks parity, keeping sticky error and overflow flags.
- Sits between a datapath slice and a shared wired-AND system bus.

Parameters:
WIDTH, 4, data/bus width in bits
DEPTH, 4, transmit FIFO entries (power of 2, >=2)
HOLD, 2, clock cycles a word is driven on the bus (>=1)
ODD, 1, 1 = odd parity over data+parity bit, 0 = even

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous active-high reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  1  0 selects a, 1 selects b for push
push  input  1  enqueue selected operand
full  output  1  FIFO full
empty  output  1  FIFO empty
count  output  $clog2(DEPTH)+1  FIFO occupancy
bus_req  output  1  bus request
bus_gnt  input  1  bus grant
bus_  inout  WIDTH  active-low wired-AND data bus, z when not driving
par_  inout  1  active-low wired-AND parity line, z when not driving
rle_  input  1  active-low receive enable
r  output  WIDTH  received true-polarity data
odd  output  1  parity bit of head entry (FIFO non-empty) else of r
perr  output  1  sticky receive parity error
ovf  output  1  sticky push-while-full
clr_flags  input  1  synchronous clear of perr/ovf
busy  output  1  FSM not IDLE

Behaviour:
- Reset (async, immediate): FIFO emptied (count=0, empty=1, full=0); FSM=IDLE; bus_req=0; bus_/par_ released to z; r=0; perr=0; ovf=0.
  - Reset mid-DRIVE releases the bus combinationally, without waiting for clk.
- Push: on rising edge with push=1 and (not full or pop same edge), writes sel?b:a.
  - Push while full with no pop: word dropped, ovf<=1.
  - Simultaneous push+pop when full: both occur, count unchanged.
- Parity bit: pbit = ^data ^ ODD, so data+pbit has odd (ODD=1) or even (ODD=0) ones.
  - Driven as par_ = ~pbit; data driven as bus_ = ~head.
- FSM states: IDLE, REQ, DRIVE, TURN.
  - IDLE: !empty -> REQ.
  - REQ: bus_req=1; bus_gnt=1 sampled -> DRIVE, hold counter cleared.
  - DRIVE: bus_req=1; bus_/par_ driven from head. Counter increments each cycle.
    - At counter==HOLD-1 -> TURN and pop the head.
    - bus_gnt=0 sampled in DRIVE: abort -> REQ, no pop, word retried.
  - TURN: one cycle, bus released, bus_req=0 -> IDLE.
- Latency: push at edge n -> bus_req=1 after edge n+1 -> bus driven after edge n+2 (gnt already high). Word is on the bus for exactly HOLD cycles.
- Minimum spacing between words: HOLD+3 cycles.
- Receive: on rising edge with rle_=0:
  - r <= ~bus_.
  - If (^(~bus_) ^ ~par_) != ODD then perr<=1.
  - rle_=1 holds r. rle_=x drives r to x (simulation only).
  - Own transmission may be received (loopback).
- clr_flags=1 clears perr/ovf. A set event in the same cycle wins (flag stays 1).
- count/full/empty are registered, consistent with FIFO pointers. Pointer wrap is modulo DEPTH, with an extra MSB to distinguish full from empty.

Decomposition:
- Shared package am29xx_pkg: FSM state encoding constants (IDLE=0, REQ=1, DRIVE=2, TURN=3) and a parity function parity(data, odd).
- One sub-module: am29xx_sfifo (WIDTH, DEPTH; push/pop/full/empty/count/head). It is reusable by other bitslice models.

Test Plan:
- Reset during DRIVE (WIDTH=4, push a=4'hA, gnt=1, assert rst after 1 drive cycle) -> bus_=zzzz immediately, count=0, bus_req=0, busy=0.
- Single transfer ODD=1: push sel=1 b=4'h6, gnt=1 -> bus_req rises 1 cycle after push; bus_=4'h9 and par_=0 (pbit=1) for exactly 2 cycles; then TURN with bus z; empty=1.
- Fill FIFO: push 5 words 1,2,3,4,5 with gnt=0 -> full=1, count=4, ovf=1; clr_flags -> ovf=0; then gnt=1 -> bus carries ~1,~2,~3,~4 in order.
- Grant withdrawal: gnt dropped in first DRIVE cycle of word 4'h3 -> FSM returns to REQ, count unchanged; regrant -> 4'h3 driven for full HOLD=2 cycles.
- Receive check: external drives bus_=4'b1110 (data 4'h1), par_=0 (pbit 1), rle_=0, ODD=1 -> r=4'h1, perr=1. With par_=1 -> perr stays 0. clr_flags -> perr=0.
- Simultaneous push+pop at full: count stays 4, the pushed word appears last in bus order, ovf=0.

Source files
------------

// File: rtl/am29xx_pkg.sv
// Shared definitions for the am29xx bitslice family.
//   xq_state_t : bus-transmit FSM encoding (IDLE=0, REQ=1, DRIVE=2, TURN=3)
//   PAR_MAXW   : widest data word the parity helper accepts
//   parity()   : reduction parity of a zero-extended word, XORed with the
//                odd/even select, giving the bit that makes data+bit odd
//                (odd=1) or even (odd=0)
package am29xx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } xq_state_t;

  localparam int PAR_MAXW = 64;

  // Callers zero-extend to PAR_MAXW; the extra zeros do not change the XOR.
  function automatic logic parity(input logic [PAR_MAXW-1:0] data,
                                  input logic                odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/am29xx_sfifo.sv
// Synchronous FIFO used as the transmit queue of the am29xx transceivers.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : enqueue din (accepted when not full, or when a pop
//                   happens on the same edge)
//   pop           : dequeue the head entry (ignored when empty)
//   head          : current head entry, valid while empty=0
//   full, empty   : registered occupancy flags
//   count         : registered occupancy, 0..DEPTH
// Pointers carry one extra MSB so that full and empty are distinguishable
// with equal low bits; wrap is modulo DEPTH (DEPTH a power of 2).
module am29xx_sfifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0] count_reg, count_next;
  logic        full_reg, empty_reg;
  logic        push_ok, pop_ok;

  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign pop_ok  = pop && !empty_reg;
  assign push_ok = push && (!full_reg || pop_ok);

  always_comb begin
    wr_ptr_next = wr_ptr_reg + (AW+1)'(push_ok);
    rd_ptr_next = rd_ptr_reg + (AW+1)'(pop_ok);
    count_next  = wr_ptr_next - rd_ptr_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == (AW+1)'(DEPTH));
      empty_reg  <= (count_next == '0);
    end
  end

  // Storage carries no reset: only entries behind the pointers are visible.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // Head is read combinationally so the word can be driven onto the bus the
  // same cycle the FSM enters DRIVE.
  assign head  = mem[rd_ptr_reg[AW-1:0]];
  assign full  = full_reg;
  assign empty = empty_reg;
  assign count = count_reg;

endmodule

// File: rtl/am2906_xq.sv
// Parity bus transceiver: operands from a/b are queued and transmitted onto
// an active-low wired-AND bus under a request/grant handshake, with a
// generated parity line; the receive side samples the bus and checks parity.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   a, b, sel, push : operand select (sel=1 -> b) and enqueue strobe
//   full, empty     : transmit FIFO flags; count = occupancy
//   bus_req/bus_gnt : bus request out, grant in
//   bus_, par_      : active-low data and parity lines, z when released
//   rle_            : active-low receive enable; r = received data
//   odd             : parity bit of the FIFO head, or of r when empty
//   perr, ovf       : sticky receive parity error / push-while-full
//   clr_flags       : clears perr/ovf (a same-cycle set wins)
//   busy            : transmit FSM not in IDLE
module am2906_xq
  import am29xx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int ODD   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     sel,
  input  logic                     push,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  inout  wire  [WIDTH-1:0]         bus_,
  inout  wire                      par_,
  input  logic                     rle_,
  output logic [WIDTH-1:0]         r,
  output logic                     odd,
  output logic                     perr,
  output logic                     ovf,
  input  logic                     clr_flags,
  output logic                     busy
);

  localparam int   HCW     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic ODD_BIT = (ODD != 0);

  // ---------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] push_data;
  logic             pop;

  assign push_data = sel ? b : a;

  am29xx_sfifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  xq_state_t      state_reg, state_next;
  logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;
  logic           hold_last;
  logic           drive_en;

  assign hold_last = (hold_cnt_reg == HCW'(HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (!empty) state_next = REQ;
      end
      REQ: begin
        if (bus_gnt) begin
          state_next    = DRIVE;
          hold_cnt_next = '0;
        end
      end
      DRIVE: begin
        // Losing the grant aborts the word; it stays at the head and is
        // re-requested from scratch.
        if (!bus_gnt) begin
          state_next = REQ;
        end else if (hold_last) begin
          state_next = TURN;
        end else begin
          hold_cnt_next = hold_cnt_reg + HCW'(1);
        end
      end
      TURN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    bus_req  = 1'b0;
    drive_en = 1'b0;
    pop      = 1'b0;
    busy     = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
      end
      REQ: begin
        bus_req = 1'b1;
      end
      DRIVE: begin
        bus_req  = 1'b1;
        // Gated by rst directly so the bus lets go the instant reset rises.
        drive_en = !rst;
        pop      = bus_gnt && hold_last;
      end
      TURN: begin
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Bus drivers (active-low data and parity)
  // ---------------------------------------------------------------------
  logic [PAR_MAXW-1:0] head_ext;
  logic                head_pbit;

  assign head_ext  = PAR_MAXW'(head);
  assign head_pbit = parity(head_ext, ODD_BIT);

  assign bus_ = drive_en ? ~head     : {WIDTH{1'bz}};
  assign par_ = drive_en ? ~head_pbit : 1'bz;

  // ---------------------------------------------------------------------
  // Receive side
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]    r_reg;
  logic                perr_reg, ovf_reg;
  logic [WIDTH-1:0]    rx_data;
  logic [PAR_MAXW-1:0] rx_ext, r_ext;
  logic                rx_perr_set;
  logic                ovf_set;

  assign rx_data     = ~bus_;
  assign rx_ext      = PAR_MAXW'(rx_data);
  // Data ones plus the true-polarity parity bit must match the selected sense.
  assign rx_perr_set = !rle_ && (parity(rx_ext, ~par_) != ODD_BIT);
  assign ovf_set     = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg    <= '0;
      perr_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      // An unknown enable poisons r in simulation; hardware sees 0 or 1.
      case (rle_)
        1'b0:    r_reg <= rx_data;
        1'b1:    r_reg <= r_reg;
        default: r_reg <= 'x;
      endcase

      if (rx_perr_set)    perr_reg <= 1'b1;
      else if (clr_flags) perr_reg <= 1'b0;

      if (ovf_set)        ovf_reg  <= 1'b1;
      else if (clr_flags) ovf_reg  <= 1'b0;
    end
  end

  assign r_ext = PAR_MAXW'(r_reg);

  assign r    = r_reg;
  assign perr = perr_reg;
  assign ovf  = ovf_reg;
  assign odd  = !empty ? head_pbit : parity(r_ext, ODD_BIT);

endmodule

// File: tb/tb_am2906_xq.sv
module tb_am2906_xq;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int ODD   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       sel, push, bus_gnt, rle_, clr_flags;
  logic       full, empty, bus_req, odd, perr, ovf, busy;
  logic [2:0] count;
  logic [3:0] r;

  // Open-collector bus with pull-ups: a released line reads 1.
  tri1 [3:0] bus_;
  tri1       par_;

  logic       ext_en;
  logic [3:0] ext_bus;
  logic       ext_par;

  assign bus_ = ext_en ? ext_bus : 4'bzzzz;
  assign par_ = ext_en ? ext_par : 1'bz;

  always #5 clk = ~clk;

  am2906_xq #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .HOLD  (HOLD),
    .ODD   (ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .push      (push),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .bus_      (bus_),
    .par_      (par_),
    .rle_      (rle_),
    .r         (r),
    .odd       (odd),
    .perr      (perr),
    .ovf       (ovf),
    .clr_flags (clr_flags),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       push;
    logic       sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       gnt;
    logic       clr;
    logic [3:0] e_bus;
    logic       e_par;
    logic       e_req;
    logic [2:0] e_cnt;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic       e_busy;
    logic       e_odd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic push_i, input logic sel_i, input logic [3:0] a_i,
                     input logic [3:0] b_i, input logic gnt_i, input logic clr_i,
                     input logic [3:0] e_bus, input logic e_par, input logic e_req,
                     input logic [2:0] e_cnt, input logic e_full, input logic e_empty,
                     input logic e_ovf, input logic e_busy, input logic e_odd);
    vec_t v;
    v.push = push_i; v.sel = sel_i; v.a = a_i; v.b = b_i; v.gnt = gnt_i; v.clr = clr_i;
    v.e_bus = e_bus; v.e_par = e_par; v.e_req = e_req; v.e_cnt = e_cnt;
    v.e_full = e_full; v.e_empty = e_empty; v.e_ovf = e_ovf; v.e_busy = e_busy;
    v.e_odd = e_odd;
    vecs.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; a = '0; b = '0; sel = 1'b0; push = 1'b0; bus_gnt = 1'b0;
    rle_ = 1'b1; clr_flags = 1'b0; ext_en = 1'b0; ext_bus = '0; ext_par = 1'b0;

    // ---------------- reset state ----------------
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_bus", 32'(bus_), 32'hF);
    check("rst_par", 32'(par_), 32'd1);
    check("rst_r", 32'(r), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_odd", 32'(odd), 32'd1);
    $display("txn reset: count=%0d empty=%b bus_=%h busy=%b", count, empty, bus_, busy);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- receive / parity check ----------------
    tick();
    ext_en = 1'b1; ext_bus = 4'b1110; ext_par = 1'b1; rle_ = 1'b0;
    tick();
    check("rx_good_r", 32'(r), 32'h1);
    check("rx_good_perr", 32'(perr), 32'd0);
    check("rx_good_odd", 32'(odd), 32'd0);
    $display("txn rx bus_=1110 par_=1: r=%h perr=%b", r, perr);
    ext_par = 1'b0;
    tick();
    check("rx_bad_r", 32'(r), 32'h1);
    check("rx_bad_perr", 32'(perr), 32'd1);
    $display("txn rx bus_=1110 par_=0: r=%h perr=%b", r, perr);
    rle_ = 1'b1; ext_bus = 4'b1010; clr_flags = 1'b1;
    tick();
    check("rx_hold_r", 32'(r), 32'h1);
    check("rx_clr_perr", 32'(perr), 32'd0);
    $display("txn rx hold+clr: r=%h perr=%b", r, perr);
    rle_ = 1'b0; ext_bus = 4'b1110; ext_par = 1'b0; clr_flags = 1'b1;
    tick();
    check("rx_setwins_perr", 32'(perr), 32'd1);
    $display("txn rx set+clr same cycle: perr=%b", perr);
    rle_ = 1'b1; clr_flags = 1'b1;
    tick();
    check("rx_clr2_perr", 32'(perr), 32'd0);
    $display("txn rx clr: perr=%b", perr);
    clr_flags = 1'b0; ext_en = 1'b0;
    tick();

    // ---------------- table-driven transfer vectors ----------------
    //   push sel a     b     gnt clr | bus   par req cnt full empty ovf busy odd
    // single transfer, b=6 selected
    add(1, 1, 4'h0, 4'h6, 1, 0,  4'hF, 1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h9, 0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h9, 0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 0, 0, 1, 0, 0, 0);
    // fill with gnt=0, overflow, clear, then drain with a grant withdrawal
    add(1, 0, 4'h1, 4'h0, 0, 0,  4'hF, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 4'h2, 4'h0, 0, 0,  4'hF, 1, 1, 2, 0, 0, 0, 1, 0);
    add(1, 0, 4'h3, 4'h0, 0, 0,  4'hF, 1, 1, 3, 0, 0, 0, 1, 0);
    add(1, 0, 4'h4, 4'h0, 0, 0,  4'hF, 1, 1, 4, 1, 0, 0, 1, 0);
    add(1, 0, 4'h5, 4'h0, 0, 0,  4'hF, 1, 1, 4, 1, 0, 1, 1, 0);
    add(0, 0, 4'h0, 4'h0, 0, 1,  4'hF, 1, 1, 4, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hE, 1, 1, 4, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hE, 1, 1, 4, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 3, 0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 3, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 1, 3, 0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hD, 1, 1, 3, 0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hD, 1, 1, 3, 0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 2, 0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 1, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hC, 0, 1, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 0, 0,  4'hF, 1, 1, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hC, 0, 1, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hC, 0, 1, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hB, 1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hB, 1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 0, 0, 1, 0, 0, 0);
    // fill, then push on the pop edge while full: word 5 goes to the tail
    add(1, 0, 4'h7, 4'h0, 0, 0,  4'hF, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 4'h8, 4'h0, 0, 0,  4'hF, 1, 1, 2, 0, 0, 0, 1, 0);
    add(1, 0, 4'h9, 4'h0, 0, 0,  4'hF, 1, 1, 3, 0, 0, 0, 1, 0);
    add(1, 1, 4'h0, 4'hA, 0, 0,  4'hF, 1, 1, 4, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h8, 1, 1, 4, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h8, 1, 1, 4, 1, 0, 0, 1, 0);
    add(1, 0, 4'h5, 4'h0, 1, 0,  4'hF, 1, 0, 4, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 4, 1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 1, 4, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h7, 1, 1, 4, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h7, 1, 1, 4, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 3, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 3, 0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 1, 3, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h6, 0, 1, 3, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h6, 0, 1, 3, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 2, 0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 1, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h5, 0, 1, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'h5, 0, 1, 2, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hA, 0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hA, 0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      push = vecs[i].push; sel = vecs[i].sel; a = vecs[i].a; b = vecs[i].b;
      bus_gnt = vecs[i].gnt; clr_flags = vecs[i].clr;
      tick();
      $display("row %0d: push=%b gnt=%b clr=%b -> bus_=%h par_=%b req=%b count=%0d full=%b empty=%b ovf=%b busy=%b odd=%b",
               i, vecs[i].push, vecs[i].gnt, vecs[i].clr, bus_, par_, bus_req, count,
               full, empty, ovf, busy, odd);
      check($sformatf("row%0d_bus", i),   32'(bus_),    32'(vecs[i].e_bus));
      check($sformatf("row%0d_par", i),   32'(par_),    32'(vecs[i].e_par));
      check($sformatf("row%0d_req", i),   32'(bus_req), 32'(vecs[i].e_req));
      check($sformatf("row%0d_count", i), 32'(count),   32'(vecs[i].e_cnt));
      check($sformatf("row%0d_full", i),  32'(full),    32'(vecs[i].e_full));
      check($sformatf("row%0d_empty", i), 32'(empty),   32'(vecs[i].e_empty));
      check($sformatf("row%0d_ovf", i),   32'(ovf),     32'(vecs[i].e_ovf));
      check($sformatf("row%0d_busy", i),  32'(busy),    32'(vecs[i].e_busy));
      check($sformatf("row%0d_odd", i),   32'(odd),     32'(vecs[i].e_odd));
    end
    push = 1'b0; clr_flags = 1'b0;

    // ---------------- reset in the middle of DRIVE ----------------
    push = 1'b1; sel = 1'b0; a = 4'hA; bus_gnt = 1'b1;
    tick();
    push = 1'b0;
    tick();
    tick();
    check("rd_drive_bus", 32'(bus_), 32'h5);
    check("rd_drive_par", 32'(par_), 32'd0);
    $display("txn drive a=A: bus_=%h par_=%b", bus_, par_);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rd_bus", 32'(bus_), 32'hF);
    check("rd_par", 32'(par_), 32'd1);
    check("rd_count", 32'(count), 32'd0);
    check("rd_empty", 32'(empty), 32'd1);
    check("rd_req", 32'(bus_req), 32'd0);
    check("rd_busy", 32'(busy), 32'd0);
    check("rd_r", 32'(r), 32'd0);
    $display("txn reset mid-drive: bus_=%h count=%0d req=%b busy=%b", bus_, count, bus_req, busy);
    #2;
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_bus", 32'(bus_), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
